// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp -- parametrised multi-port register file for the decode stage.
//
// Holds 2**ADDR_W registers of DATA_W bits. It has NUM_READ combinational
// read ports feeding ID and NUM_WRITE synchronous write ports driven from WB
// and the second retire path. A per-register pending-write scoreboard lets ID
// detect RAW hazards.
//
// Parameters
//   DATA_W     register width in bits
//   ADDR_W     address width, depth = 2**ADDR_W
//   NUM_READ   number of read ports (1..4)
//   NUM_WRITE  number of write ports (1..2). On a same-address collision the
//              highest-indexed port wins.
//   ZERO_REG   1 = entry 0 reads 0 and ignores writes and claims
//   BYPASS     1 = same-cycle write data and busy-clear are forwarded to reads
//
// Ports
//   clk, rst_n   rising-edge clock and asynchronous active-low reset
//   rd_addr      NUM_READ packed read addresses; port i is [i*ADDR_W +: ADDR_W]
//   rd_data      NUM_READ packed read data, same packing
//   rd_busy      per read port: the addressed register has an outstanding claim
//   wr_en        per write port enable
//   wr_addr      NUM_WRITE packed write addresses
//   wr_data      NUM_WRITE packed write data
//   claim_en     ID issues an instruction that will write claim_addr
//   claim_addr   destination register being claimed
//   busy_vec     raw scoreboard state; bit n = register n pending
// -----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_READ*ADDR_W-1:0]    rd_addr,
    output logic [NUM_READ*DATA_W-1:0]    rd_data,
    output logic [NUM_READ-1:0]           rd_busy,
    input  logic [NUM_WRITE-1:0]          wr_en,
    input  logic [NUM_WRITE*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WRITE*DATA_W-1:0]   wr_data,
    input  logic                          claim_en,
    input  logic [ADDR_W-1:0]             claim_addr,
    output logic [(1<<ADDR_W)-1:0]        busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    // Architectural state.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;

    // Per-entry write decode after resolving port priority: wr_hit[n] says
    // entry n is written this cycle, and wr_val[n] holds the data of the
    // winning port.
    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [DEPTH];

    // Per-entry claim decode and next scoreboard state.
    logic [DEPTH-1:0]  claim_hit;
    logic [DEPTH-1:0]  busy_d;

    // Unpacked view of the read addresses.
    logic [ADDR_W-1:0] ra [NUM_READ];

    // -------------------------------------------------------------------------
    // Write decode. Ports are scanned in ascending order, so the last match
    // (the highest-indexed port) overrides the earlier ones. Gating with
    // rst_n drops in-flight writes while reset is held. This also keeps the
    // bypass path from forwarding data while the outputs must read 0.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a variable unassigned would infer a latch.
        wr_hit = '0;
        for (int n = 0; n < DEPTH; n++) begin
            wr_val[n] = '0;
        end
        for (int n = 0; n < DEPTH; n++) begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (rst_n && wr_en[j] &&
                    (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(n))) begin
                    wr_hit[n] = 1'b1;
                    wr_val[n] = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
        if (ZERO_REG != 0) begin
            wr_hit[0] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state. A claim takes priority over a same-cycle clear,
    // because the claim belongs to a newer producer that is still in flight.
    // ID stall logic guarantees at most one producer per register, so a
    // single bit per entry is enough.
    // -------------------------------------------------------------------------
    always_comb begin
        claim_hit = '0;
        if (claim_en && rst_n) begin
            claim_hit[claim_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            claim_hit[0] = 1'b0;
        end
        busy_d = claim_hit | (busy_q & ~wr_hit);
    end

    // -------------------------------------------------------------------------
    // State registers. Every entry is reset, so no read can ever return X.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset explicitly entry by entry.
            // This costs a reset net per flop, but it guarantees defined
            // read data from the first cycle.
            for (int n = 0; n < DEPTH; n++) begin
                mem_q[n] <= '0;
            end
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // entry samples the pre-edge values regardless of statement order.
            for (int n = 0; n < DEPTH; n++) begin
                if (wr_hit[n]) begin
                    mem_q[n] <= wr_val[n];
                end
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // -------------------------------------------------------------------------
    // Read ports: combinational, zero-cycle latency.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_data[i*DATA_W +: DATA_W] = mem_q[ra[i]];
            rd_busy[i]                  = busy_q[ra[i]];
            // With bypass, a same-cycle write supplies the data. The hazard
            // is also resolved, so the busy flag is suppressed.
            if ((BYPASS != 0) && wr_hit[ra[i]]) begin
                rd_data[i*DATA_W +: DATA_W] = wr_val[ra[i]];
                rd_busy[i]                  = 1'b0;
            end
            // Entry 0 is never written and never claimed when hardwired.
            // Forcing the read here as well keeps the output independent of
            // the storage path.
            if ((ZERO_REG != 0) && (ra[i] == '0)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_busy[i]                  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp -- self-checking bench for reg_file_mp.
//
// Two instances share the same stimulus:
//   dut_a: 2 write ports, BYPASS=1, ZERO_REG=1
//   dut_b: 1 write port (port 0 of the stimulus), BYPASS=0, ZERO_REG=0
// A reference model of each (register array plus pending bits) predicts every
// output. Directed scenarios run first, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [31:0] busy_vec_a, busy_vec_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: [0] mirrors dut_a, [1] mirrors dut_b.
    logic [31:0] mem_m  [2][32];
    bit          busy_m [2][32];

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .NUM_WRITE(2),
        .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec_a)
    );

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_READ(2), .NUM_WRITE(1),
        .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write that lands on register a in instance d this cycle. Ports are
    // scanned in order, so the later port's data is the one that survives.
    function automatic void winner(input int d, input logic [4:0] a,
                                   output bit hit, output logic [31:0] val);
        int nw;
        nw  = (d == 0) ? 2 : 1;
        hit = 1'b0;
        val = '0;
        if (rst_n !== 1'b1) return;
        if (d == 0 && a == 5'd0) return;
        for (int j = 0; j < nw; j++) begin
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin
                hit = 1'b1;
                val = wr_data[j*32 +: 32];
            end
        end
    endfunction

    task automatic check_model();
        bit          hit;
        logic [31:0] val, exp_d, got_d;
        logic        exp_b, got_b;
        logic [4:0]  a;
        logic [31:0] exp_vec;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                a = rd_addr[i*5 +: 5];
                winner(d, a, hit, val);
                if (rst_n !== 1'b1 || (d == 0 && a == 5'd0)) begin
                    exp_d = '0; exp_b = 1'b0;
                end else if (d == 0 && hit) begin
                    exp_d = val; exp_b = 1'b0;
                end else begin
                    exp_d = mem_m[d][a]; exp_b = busy_m[d][a];
                end
                got_d = (d == 0) ? rd_data_a[i*32 +: 32] : rd_data_b[i*32 +: 32];
                got_b = (d == 0) ? rd_busy_a[i] : rd_busy_b[i];
                check($sformatf("dut%0d_rd%0d_data_r%0d", d, i, a), got_d, exp_d);
                check($sformatf("dut%0d_rd%0d_busy_r%0d", d, i, a), got_b, exp_b);
            end
            for (int n = 0; n < 32; n++) exp_vec[n] = busy_m[d][n];
            check($sformatf("dut%0d_busy_vec", d),
                  (d == 0) ? busy_vec_a : busy_vec_b, exp_vec);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 32; n++) begin
                mem_m[d][n]  = '0;
                busy_m[d][n] = 1'b0;
            end
    endtask

    task automatic update_model();
        bit          hit [2][32];
        logic [31:0] val [2][32];
        bit          claim;
        if (rst_n !== 1'b1) return;
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 32; n++) winner(d, 5'(n), hit[d][n], val[d][n]);
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 32; n++) begin
                claim = claim_en && claim_addr == 5'(n) && !(d == 0 && n == 0);
                if (hit[d][n]) mem_m[d][n] = val[d][n];
                if (claim)          busy_m[d][n] = 1'b1;
                else if (hit[d][n]) busy_m[d][n] = 1'b0;
            end
    endtask

    // Inputs are applied at the falling edge. Outputs are sampled 1 ns later
    // and the model advances at the rising edge.
    task automatic sample();
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic quiet();
        wr_en    = 2'b00;
        claim_en = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] v);
        wr_en[j]          = 1'b1;
        wr_addr[j*5 +: 5] = a;
        wr_data[j*32 +: 32] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
        quiet();
        clear_model();
        @(negedge clk);
        // Writes and claims presented during reset must be discarded.
        set_wr(0, 5'd2, 32'h5555_AAAA); set_wr(1, 5'd3, 32'h1);
        claim_en = 1'b1; claim_addr = 5'd2; set_rd(5'd2, 5'd3);
        sample();
        advance();
        quiet();
        rst_n = 1'b1;

        // Test 1: all addresses read zero and nothing is busy after reset.
        for (int k = 0; k < 32; k++) begin
            set_rd(5'(k), 5'(31 - k));
            sample();
            advance();
        end

        // Test 2: plain write, then a write to r0.
        set_wr(0, 5'd5, 32'hDEAD_BEEF); set_rd(5'd5, 5'd0);
        sample(); advance(); quiet();
        sample();
        check("r5_a", rd_data_a[31:0], 32'hDEAD_BEEF);
        check("r5_b", rd_data_b[31:0], 32'hDEAD_BEEF);
        set_wr(0, 5'd0, 32'h1234);
        sample(); advance(); quiet();
        sample();
        check("r0_a_zero", rd_data_a[63:32], 32'h0);
        check("r0_b_plain", rd_data_b[63:32], 32'h1234);

        // Test 3: bypass against non-bypass on r7 read through port 1.
        set_rd(5'd5, 5'd7); set_wr(0, 5'd7, 32'hCAFE_F00D);
        sample();
        check("r7_a_bypass", rd_data_a[63:32], 32'hCAFE_F00D);
        check("r7_b_old", rd_data_b[63:32], 32'h0);
        advance(); quiet();
        sample();
        check("r7_b_new", rd_data_b[63:32], 32'hCAFE_F00D);

        // Test 4: both ports write r9, and the higher port wins.
        set_rd(5'd9, 5'd9); set_wr(0, 5'd9, 32'h11); set_wr(1, 5'd9, 32'h22);
        sample();
        check("r9_a_bypass_prio", rd_data_a[31:0], 32'h22);
        advance(); quiet();
        sample();
        check("r9_a_prio", rd_data_a[31:0], 32'h22);

        // Test 5: scoreboard claim, clear, and claim winning over clear.
        set_rd(5'd3, 5'd3); claim_en = 1'b1; claim_addr = 5'd3;
        sample(); advance(); quiet();
        sample();
        check("r3_busy_a", rd_busy_a[0], 1'b1);
        set_wr(0, 5'd3, 32'h33);
        sample();
        check("r3_busy_a_fwd", rd_busy_a[0], 1'b0);
        check("r3_busy_b_nofwd", rd_busy_b[0], 1'b1);
        advance(); quiet();
        sample();
        check("r3_vec_cleared", busy_vec_a[3], 1'b0);
        claim_en = 1'b1; claim_addr = 5'd3; set_wr(0, 5'd3, 32'h34);
        sample(); advance(); quiet();
        sample();
        check("r3_vec_claim_wins", busy_vec_a[3], 1'b1);
        check("r3_vec_claim_wins_b", busy_vec_b[3], 1'b1);
        claim_en = 1'b1; claim_addr = 5'd0;
        sample(); advance(); quiet();
        sample();
        check("r0_claim_ignored_a", busy_vec_a[0], 1'b0);

        // Test 6: reset pulse between edges clears state immediately.
        set_wr(0, 5'd4, 32'hAA); claim_en = 1'b1; claim_addr = 5'd6;
        sample(); advance(); quiet();
        set_rd(5'd4, 5'd6);
        sample();
        #1 rst_n = 1'b0;
        clear_model();
        sample();
        check("r4_reset_a", rd_data_a[31:0], 32'h0);
        check("vec_reset_a", busy_vec_a, 32'h0);
        #1 rst_n = 1'b1;
        sample();
        advance();

        // Random traffic on a small address window to force collisions.
        for (int c = 0; c < 1500; c++) begin
            quiet();
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            for (int j = 0; j < 2; j++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(j, 5'($urandom_range(0, 7)), $urandom);
            claim_en   = ($urandom_range(0, 2) == 0);
            claim_addr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                sample();
                #1 rst_n = 1'b0;
                clear_model();
                sample();
                #1 rst_n = 1'b1;
            end
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, dual-read decode-stage register file.
- Adds:
  - configurable width, depth, read-port count and write-port count
  - asynchronous active-low reset of all entries
  - hardwired zero register
  - optional write-to-read bypass
  - per-register pending-write scoreboard for hazard detection in ID
- Sits in decode. Read ports feed ID. Write ports are driven from WB (and a second retire path when NUM_WRITE=2).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_READ, 2, number of read ports (1..4)
- NUM_WRITE, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes and claims
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_READ*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_READ*DATA_W  read data, same packing
- rd_busy  out  NUM_READ  addressed register has an outstanding claim
- wr_en  in  NUM_WRITE  write enable per port
- wr_addr  in  NUM_WRITE*ADDR_W  write addresses
- wr_data  in  NUM_WRITE*DATA_W  write data
- claim_en  in  1  ID issues an instruction that will write claim_addr
- claim_addr  in  ADDR_W  destination being claimed
- busy_vec  out  2**ADDR_W  raw scoreboard state, bit n = register n pending

Behaviour:
- Reset:
  - rst_n low asynchronously clears every entry to 0 and busy_vec to 0.
  - rd_data therefore reads 0 and rd_busy reads 0 while reset is held.
  - Reset mid-operation discards in-flight writes and claims that cycle.
- Reads are combinational, zero-cycle latency from rd_addr.
- Writes:
  - Committed on rising clk when wr_en[j]=1; visible in storage from the next cycle.
  - Two write ports to the same address in the same cycle: port NUM_WRITE-1 (highest index) wins.
- Bypass, BYPASS=1:
  - If any wr_en[j] && wr_addr[j]==rd_addr[i], rd_data[i] returns the winning port's wr_data in the same cycle.
  - BYPASS=0: rd_data[i] returns old stored contents until the following cycle.
- Zero register, ZERO_REG=1:
  - Address 0 always reads 0, with or without bypass.
  - Writes to 0 are ignored.
  - busy_vec[0] is constant 0 and claims to 0 are ignored.
- Scoreboard, per entry n:
  - Set on the clock edge when claim_en && claim_addr==n.
  - Cleared on the clock edge when any wr_en[j] && wr_addr[j]==n.
  - Claim and clear of the same n in the same cycle: claim wins and the bit stays 1 (a newer producer is in flight).
  - Claiming an already-busy register keeps it 1; no counting, since a single outstanding producer is guaranteed by ID stall logic.
  - Write to a non-busy register: data written, bit stays 0.
- rd_busy[i] = busy_vec[rd_addr[i]], except:
  - When BYPASS=1 and a write to that address occurs this cycle, rd_busy[i]=0, because the data is forwarded.
  - ZERO_REG=1 with address 0 gives rd_busy=0.
- Write-before-read within the cycle applies only through bypass. No read-during-reset-release hazard: the first edge after rst_n rises may write.
- No X propagation: storage is fully reset and all outputs are defined for every address.

Test Plan:
1. Reset, then read all 32 addresses on both ports. Expect rd_data=0, rd_busy=0, busy_vec=0.
2. Write 0xDEADBEEF to r5, read r5 next cycle. Expect 0xDEADBEEF. Write 0x1234 to r0, read r0. Expect 0.
3. BYPASS=1: write 0xCAFEF00D to r7 while rd_addr port1=7. Expect 0xCAFEF00D the same cycle. Repeat with BYPASS=0: expect the old value, then the new value next cycle.
4. NUM_WRITE=2: both ports write r9, port0=0x11 and port1=0x22. Expect r9=0x22.
5. Scoreboard:
   - Claim r3. Next cycle rd_busy for r3 = 1.
   - WB writes r3 with claim_en=0. Expect rd_busy=0 the same cycle when BYPASS=1, and busy_vec[3]=0 next cycle.
   - Simultaneous claim and write of r3. Expect busy_vec[3]=1 afterwards.
6. Set r4=0xAA and claim r6, then pulse rst_n low between clock edges. Expect r4 reads 0 and busy_vec=0 immediately, with no clock edge needed.
